regbus_arbiter: RTL

Two-requester arbiter and sequencer for the peripheral register-file bus (UART status/config/data and LED registers). It sits between the core's data port (requester 0) and the debug port (requester 1) on one side, and the register file's write/read strobe interface on the other. It serializes accesses with round-robin fairness, issues registered write and read strobes, waits for the register file's read-ready pulse, and returns read data to the owning requester, with a read timeout.

---
 rtl/regbus_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter/sequencer between the core and debug ports and the
// peripheral register file: serialized writes, reads with timeout, registered strobes.
module regbus_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int BW         = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [BW-1:0] m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rerr,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [BW-1:0] m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rerr,
  output logic          wr_en,
  output logic          rd_en,
  output logic [BW-1:0] be,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          rd_rdy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR      = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(RD_TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;
  logic          r_prio, w_prio_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;

  logic          w_win, w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [BW-1:0] w_win_be;
  logic [DW-1:0] w_win_wdata;

  logic          w_load, w_wr_en_nxt, w_rd_en_nxt, w_cap_err;
  logic [1:0]    w_gnt_nxt, w_rvalid_nxt;
  logic [DW-1:0] w_cap_data;

  logic          r_wr_en, r_rd_en, r_m0_rerr, r_m1_rerr;
  logic [1:0]    r_gnt, r_rvalid;
  logic [BW-1:0] r_be;
  logic [AW-1:0] r_wr_addr, r_rd_addr;
  logic [DW-1:0] r_wdata, r_m0_rdata, r_m1_rdata;

  // Winner selection: a lone requester wins, contention goes to the prio pointer
  always_comb begin
    w_win       = (m0_req & m1_req) ? r_prio : m1_req;
    w_win_we    = w_win ? m1_we    : m0_we;
    w_win_addr  = w_win ? m1_addr  : m0_addr;
    w_win_be    = w_win ? m1_be    : m0_be;
    w_win_wdata = w_win ? m1_wdata : m0_wdata;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_prio_nxt   = r_prio;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_wr_en_nxt  = 1'b0;
    w_rd_en_nxt  = 1'b0;
    w_gnt_nxt    = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_cap_data   = {DW{1'b0}};
    w_cap_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          w_load      = 1'b1;
          w_owner_nxt = w_win;
          w_prio_nxt  = ~w_win;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_cnt_nxt   = 8'd0;
          if (w_win_we) begin
            w_state_nxt = S_WR;
            w_wr_en_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RD_WAIT;
            w_rd_en_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        w_state_nxt = S_IDLE;
      end
      S_RD_WAIT: begin
        if (rd_rdy) begin
          w_cap_data   = rdata;
          w_state_nxt  = S_RESP;
          w_rvalid_nxt = r_owner ? 2'b10 : 2'b01;
        end else if (r_cnt == TO_CNT) begin
          // Timeout completes with zero data and the error flag
          w_cap_err    = 1'b1;
          w_state_nxt  = S_RESP;
          w_rvalid_nxt = r_owner ? 2'b10 : 2'b01;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer and registered output update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_cnt      <= 8'd0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_gnt      <= 2'b00;
      r_rvalid   <= 2'b00;
      r_be       <= {BW{1'b0}};
      r_wr_addr  <= {AW{1'b0}};
      r_rd_addr  <= {AW{1'b0}};
      r_wdata    <= {DW{1'b0}};
      r_m0_rdata <= {DW{1'b0}};
      r_m1_rdata <= {DW{1'b0}};
      r_m0_rerr  <= 1'b0;
      r_m1_rerr  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_prio   <= w_prio_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      if (w_load && w_win_we) begin
        r_wr_addr <= w_win_addr;
        r_be      <= w_win_be;
        r_wdata   <= w_win_wdata;
      end
      if (w_load && !w_win_we) begin
        r_rd_addr <= w_win_addr;
      end
      // Read data/error hold until the next completion for the same requester
      if (w_rvalid_nxt[0]) begin
        r_m0_rdata <= w_cap_data;
        r_m0_rerr  <= w_cap_err;
      end
      if (w_rvalid_nxt[1]) begin
        r_m1_rdata <= w_cap_data;
        r_m1_rerr  <= w_cap_err;
      end
    end
  end

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_rerr   = r_m0_rerr;
  assign m1_rerr   = r_m1_rerr;
  assign wr_en     = r_wr_en;
  assign rd_en     = r_rd_en;
  assign be        = r_be;
  assign wr_addr   = r_wr_addr;
  assign rd_addr   = r_rd_addr;
  assign wdata     = r_wdata;

endmodule
